// File: rtl/mult_pipe_gen.sv
// Pipelined integer multiply unit with CDB back-pressure and ROB-relative squash.
// Each stage folds one operand-B chunk into a 2*XLEN accumulator; results leave in issue order.
module mult_pipe_gen #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned ROB_W     = 5,
    parameter int unsigned PR_W      = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        in_func,
    input  logic [XLEN-1:0]   in_opa,
    input  logic [XLEN-1:0]   in_opb,
    input  logic [PR_W-1:0]   in_T_idx,
    input  logic [ROB_W-1:0]  in_ROB_idx,
    output logic              in_ready,
    output logic              out_done,
    output logic [XLEN-1:0]   out_result,
    output logic [PR_W-1:0]   out_T_idx,
    output logic [ROB_W-1:0]  out_ROB_idx,
    input  logic              CDB_valid,
    input  logic              ROB_rollback_en,
    input  logic [ROB_W-1:0]  ROB_rollback_idx,
    input  logic [ROB_W-1:0]  ROB_tail_idx
);

    localparam int unsigned ChunkW = XLEN / NUM_STAGE;
    localparam int unsigned AccW   = 2 * XLEN;

    logic                 valid_q [NUM_STAGE];
    logic                 valid_d [NUM_STAGE];
    logic [1:0]           func_q  [NUM_STAGE];
    logic [1:0]           func_d  [NUM_STAGE];
    logic [XLEN-1:0]      opa_q   [NUM_STAGE];
    logic [XLEN-1:0]      opa_d   [NUM_STAGE];
    logic [XLEN-1:0]      opb_q   [NUM_STAGE];
    logic [XLEN-1:0]      opb_d   [NUM_STAGE];
    logic [PR_W-1:0]      tidx_q  [NUM_STAGE];
    logic [PR_W-1:0]      tidx_d  [NUM_STAGE];
    logic [ROB_W-1:0]     rob_q   [NUM_STAGE];
    logic [ROB_W-1:0]     rob_d   [NUM_STAGE];
    logic [AccW-1:0]      acc_q   [NUM_STAGE];
    logic [AccW-1:0]      acc_d   [NUM_STAGE];
    logic [NUM_STAGE-1:0] adv;
    logic [AccW-1:0]      acc_last;

    // Younger than the mispredicted branch iff 0 < (idx - rb) < (tail - rb), all modulo ROB size.
    function automatic logic squash(input logic              en,
                                    input logic [ROB_W-1:0]  idx,
                                    input logic [ROB_W-1:0]  rb,
                                    input logic [ROB_W-1:0]  tail);
        logic [ROB_W-1:0] d_idx;
        logic [ROB_W-1:0] d_tail;
        d_idx  = idx - rb;
        d_tail = tail - rb;
        return en && (d_idx != '0) && (d_idx < d_tail);
    endfunction

    function automatic logic [AccW-1:0] partial(input logic [XLEN-1:0]   a,
                                                input logic [ChunkW-1:0] c,
                                                input int unsigned       s);
        logic [AccW-1:0] ext_a;
        logic [AccW-1:0] ext_c;
        ext_a = AccW'(a);
        ext_c = AccW'(c);
        return (ext_a * ext_c) << (s * ChunkW);
    endfunction

    always_comb begin
        adv[NUM_STAGE-1] = !valid_q[NUM_STAGE-1] || CDB_valid;
        for (int unsigned k = 1; k < NUM_STAGE; k++) begin
            adv[NUM_STAGE-1-k] = !valid_q[NUM_STAGE-1-k] || adv[NUM_STAGE-k];
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        for (int unsigned s = 0; s < NUM_STAGE; s++) begin
            valid_d[s] = valid_q[s] && !squash(ROB_rollback_en, rob_q[s], ROB_rollback_idx,
                                               ROB_tail_idx);
            func_d[s]  = func_q[s];
            opa_d[s]   = opa_q[s];
            opb_d[s]   = opb_q[s];
            tidx_d[s]  = tidx_q[s];
            rob_d[s]   = rob_q[s];
            acc_d[s]   = acc_q[s];
        end

        if (adv[0]) begin
            valid_d[0] = in_valid && !squash(ROB_rollback_en, in_ROB_idx, ROB_rollback_idx,
                                             ROB_tail_idx);
            if (in_valid) begin
                func_d[0] = in_func;
                opa_d[0]  = in_opa;
                opb_d[0]  = in_opb;
                tidx_d[0] = in_T_idx;
                rob_d[0]  = in_ROB_idx;
                acc_d[0]  = partial(in_opa, in_opb[ChunkW-1:0], 0);
            end
        end

        for (int unsigned s = 1; s < NUM_STAGE; s++) begin
            if (adv[s]) begin
                valid_d[s] = valid_q[s-1] && !squash(ROB_rollback_en, rob_q[s-1],
                                                     ROB_rollback_idx, ROB_tail_idx);
                // Payload only moves with a real entry so bubbles leave the registers untouched.
                if (valid_q[s-1]) begin
                    func_d[s] = func_q[s-1];
                    opa_d[s]  = opa_q[s-1];
                    opb_d[s]  = opb_q[s-1];
                    tidx_d[s] = tidx_q[s-1];
                    rob_d[s]  = rob_q[s-1];
                    acc_d[s]  = acc_q[s-1]
                              + partial(opa_q[s-1], opb_q[s-1][s*ChunkW +: ChunkW], s);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < NUM_STAGE; s++) begin
                valid_q[s] <= 1'b0;
                func_q[s]  <= '0;
                opa_q[s]   <= '0;
                opb_q[s]   <= '0;
                tidx_q[s]  <= '0;
                rob_q[s]   <= '0;
                acc_q[s]   <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NUM_STAGE; s++) begin
                valid_q[s] <= valid_d[s];
                func_q[s]  <= func_d[s];
                opa_q[s]   <= opa_d[s];
                opb_q[s]   <= opb_d[s];
                tidx_q[s]  <= tidx_d[s];
                rob_q[s]   <= rob_d[s];
                acc_q[s]   <= acc_d[s];
            end
        end
    end

    always_comb begin
        acc_last   = acc_q[NUM_STAGE-1];
        out_result = acc_last[XLEN-1:0];
        case (func_q[NUM_STAGE-1])
            2'b01:   out_result = acc_last[AccW-1:XLEN];
            2'b10:   out_result = XLEN'($signed(acc_last[31:0]));
            default: out_result = acc_last[XLEN-1:0];
        endcase
    end

    assign out_done    = valid_q[NUM_STAGE-1];
    assign out_T_idx   = tidx_q[NUM_STAGE-1];
    assign out_ROB_idx = rob_q[NUM_STAGE-1];

endmodule

// File: tb/tb_mult_pipe_gen.sv
// Bench for mult_pipe_gen: directed steps plus random traffic against an in-order queue model.
module tb_mult_pipe_gen;

    localparam int NS = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_func;
    logic [63:0] in_opa;
    logic [63:0] in_opb;
    logic [5:0]  in_T_idx;
    logic [4:0]  in_ROB_idx;
    logic        in_ready;
    logic        out_done;
    logic [63:0] out_result;
    logic [5:0]  out_T_idx;
    logic [4:0]  out_ROB_idx;
    logic        CDB_valid;
    logic        ROB_rollback_en;
    logic [4:0]  ROB_rollback_idx;
    logic [4:0]  ROB_tail_idx;

    mult_pipe_gen #(
        .XLEN      (64),
        .NUM_STAGE (NS),
        .ROB_W     (5),
        .PR_W      (6)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_func          (in_func),
        .in_opa           (in_opa),
        .in_opb           (in_opb),
        .in_T_idx         (in_T_idx),
        .in_ROB_idx       (in_ROB_idx),
        .in_ready         (in_ready),
        .out_done         (out_done),
        .out_result       (out_result),
        .out_T_idx        (out_T_idx),
        .out_ROB_idx      (out_ROB_idx),
        .CDB_valid        (CDB_valid),
        .ROB_rollback_en  (ROB_rollback_en),
        .ROB_rollback_idx (ROB_rollback_idx),
        .ROB_tail_idx     (ROB_tail_idx)
    );

    typedef struct {
        logic [63:0] res;
        logic [5:0]  t;
        logic [4:0]  rob;
        int          rdy;
    } ent_t;

    ent_t q[$];
    int   cyc;
    int   last_dep;
    int   n_chk;
    int   n_fail;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] ref_mul(input logic [1:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  lo;
        p  = {64'd0, a} * {64'd0, b};
        lo = p[31:0];
        case (f)
            2'b01:   return p[127:64];
            2'b10:   return {{32{lo[31]}}, lo};
            default: return p[63:0];
        endcase
    endfunction

    function automatic bit younger(input int idx, input int rb, input int tl);
        int di;
        int dt;
        di = (idx - rb + 32) % 32;
        dt = (tl - rb + 32) % 32;
        return (di > 0) && (di < dt);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of stimulus; checks outputs against the model before the edge.
    task automatic step(input bit v, input logic [1:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] t, input logic [4:0] r,
                        input bit cdb, input bit rb, input logic [4:0] rbi,
                        input logic [4:0] tl);
        ent_t e;
        bit   exp_done;
        bit   exp_ready;
        int   at;
        in_valid         = v;
        in_func          = f;
        in_opa           = a;
        in_opb           = b;
        in_T_idx         = t;
        in_ROB_idx       = r;
        CDB_valid        = cdb;
        ROB_rollback_en  = rb;
        ROB_rollback_idx = rbi;
        ROB_tail_idx     = tl;
        @(negedge clock);
        exp_done = 1'b0;
        if (q.size() > 0) begin
            at       = (q[0].rdy > last_dep) ? q[0].rdy : last_dep;
            exp_done = (at <= cyc);
        end
        exp_ready = (q.size() < NS) || cdb;
        chk("out_done", 64'(out_done), 64'(exp_done));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        if (exp_done) begin
            chk("out_result", out_result, q[0].res);
            chk("out_T_idx", 64'(out_T_idx), 64'(q[0].t));
            chk("out_ROB_idx", 64'(out_ROB_idx), 64'(q[0].rob));
            if (cdb) begin
                void'(q.pop_front());
                last_dep = cyc + 1;
            end
        end
        if (rb) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (younger(int'(q[i].rob), int'(rbi), int'(tl))) q.delete(i);
            end
        end
        if (v && exp_ready && !(rb && younger(int'(r), int'(rbi), int'(tl)))) begin
            e.res = ref_mul(f, a, b);
            e.t   = t;
            e.rob = r;
            e.rdy = cyc + NS;
            q.push_back(e);
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic issue(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] t, input logic [4:0] r);
        step(1'b1, f, a, b, t, r, 1'b1, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 64'd0, 64'd0, 6'd0, 5'd0, 1'b1, 1'b0,
                                         5'd0, 5'd0);
    endtask

    logic [63:0] ta [8];
    logic [63:0] tb [8];
    logic [4:0]  rob_ctr;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; last_dep = 0;
        ta = '{64'd1, 64'd64, 64'd3, 64'd5, 64'd12, 64'd57, 64'd2, 64'd24};
        tb = '{64'd2, 64'd2, 64'd7, 64'd66, 64'd14, 64'd89, 64'd33, 64'd75};

        // Reset held with a pending issue: nothing may be captured.
        reset = 1'b1; in_valid = 1'b1; in_func = 2'b00; in_opa = 64'd3; in_opb = 64'd7;
        in_T_idx = 6'd1; in_ROB_idx = 5'd1; CDB_valid = 1'b1; ROB_rollback_en = 1'b0;
        ROB_rollback_idx = 5'd0; ROB_tail_idx = 5'd0;
        repeat (2) begin
            @(negedge clock);
            chk("rst_done", 64'(out_done), 64'd0);
            chk("rst_result", out_result, 64'd0);
            chk("rst_rob", 64'(out_ROB_idx), 64'd0);
            chk("rst_t", 64'(out_T_idx), 64'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        idle(2);

        issue(2'b00, 64'd3, 64'd7, 6'd9, 5'd2);
        idle(6);

        for (int i = 0; i < 8; i++) issue(2'b00, ta[i], tb[i], 6'(i + 10), 5'(i + 1));
        idle(6);

        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd20, 5'd10);
        issue(2'b10, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'd21, 5'd11);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd22, 5'd12);
        issue(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 6'd23, 5'd13);
        idle(6);

        // Back-pressure: fill the pipe with the CDB blocked, then release it.
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'b00, 64'(i + 100), 64'(i + 3), 6'(i + 30), 5'(i + 14), 1'b0, 1'b0,
                 5'd0, 5'd0);
        repeat (3) step(1'b1, 2'b00, 64'd104, 64'd7, 6'd34, 5'd18, 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'b00, 64'd104, 64'd7, 6'd34, 5'd18, 1'b1, 1'b0, 5'd0, 5'd0);
        issue(2'b00, 64'd105, 64'd8, 6'd35, 5'd19);
        idle(8);

        // Rollback: ROB 3..6 in flight, ROB 7 issuing; branch 5, tail 2.
        for (int i = 3; i <= 6; i++) issue(2'b00, 64'(i), 64'd11, 6'(i), 5'(i));
        step(1'b1, 2'b00, 64'd7, 64'd11, 6'd7, 5'd7, 1'b1, 1'b1, 5'd5, 5'd2);
        idle(6);
        // Wrapped window: ROB 0 and 1 are younger than 5 with tail 2, ROB 2 is not.
        for (int i = 0; i <= 2; i++) issue(2'b00, 64'(i + 40), 64'd13, 6'(i + 40), 5'(i));
        step(1'b0, 2'b00, 64'd0, 64'd0, 6'd0, 5'd0, 1'b1, 1'b1, 5'd5, 5'd2);
        idle(6);

        rob_ctr = 5'd0;
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit c;
            bit rb;
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 3) != 0);
            rb = c && ($urandom_range(0, 15) == 0);
            step(v, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                 6'($urandom_range(0, 63)), rob_ctr, c, rb, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
            if (v) rob_ctr = rob_ctr + 5'd1;
        end
        idle(8);

        // Reset in the middle of traffic drops everything in flight.
        issue(2'b00, 64'd9, 64'd9, 6'd1, 5'd1);
        issue(2'b00, 64'd8, 64'd8, 6'd2, 5'd2);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_done", 64'(out_done), 64'd0);
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(6);

        chk("drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_pipe_gen.md
Name: mult_pipe_gen

Overview:
Parametrised pipelined integer multiply functional unit. It generalises the fixed-stage MULQ unit: configurable operand width and stage count, three multiply modes (MULQ, UMULH, MULL), per-stage stall back-pressure from the CDB, and ROB-relative squash on branch rollback. It sits between the RS issue port and the CDB arbiter. Results leave in issue order.

Parameters:
XLEN, 64, operand/result width; must be even.
NUM_STAGE, 4, pipeline depth (issue-to-done latency); XLEN % NUM_STAGE == 0.
ROB_W, 5, ROB index width; ROB size is 2**ROB_W.
PR_W, 6, physical-register tag width.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  issue request from RS this cycle.
in_func  in  2  00=MULQ (low XLEN bits), 01=UMULH (unsigned high XLEN bits), 10=MULL (low 32-bit product sign-extended to XLEN), 11=reserved (treated as MULQ).
in_opa  in  XLEN  operand A.
in_opb  in  XLEN  operand B.
in_T_idx  in  PR_W  destination physical register.
in_ROB_idx  in  ROB_W  ROB tag.
in_ready  out  1  unit can accept an issue this cycle (fu_valid to RS).
out_done  out  1  final stage holds a valid result.
out_result  out  XLEN  result.
out_T_idx  out  PR_W  tag of result.
out_ROB_idx  out  ROB_W  ROB tag of result.
CDB_valid  in  1  CDB accepts the result presented this cycle.
ROB_rollback_en  in  1  branch mispredict rollback.
ROB_rollback_idx  in  ROB_W  ROB index of the mispredicted branch.
ROB_tail_idx  in  ROB_W  ROB tail (next free slot).

Behaviour:
- Reset: all stage valids 0. out_done=0, out_result=0, out_T_idx=0, out_ROB_idx=0. in_ready=1 once reset deasserts. Reset mid-operation discards all in-flight entries with no output.
- Stage s (0..NUM_STAGE-1) holds: valid, func, opa, opb, T_idx, ROB_idx, and a 2*XLEN partial-product accumulator.
- Each stage adds opa × (XLEN/NUM_STAGE-bit chunk s of opb), shifted by s*XLEN/NUM_STAGE, into the accumulator.
- Product arithmetic: MULQ and UMULH use the unsigned 2*XLEN product. MULQ takes the low half, UMULH the high half.
- MULL: result = sign-extend(product[31:0]). The low 32 bits are sign-independent, so the unsigned product is used.
- Final stage: selects the result per func and drives the out_* fields from its registers; out_done = its valid.
- Advance rule:
  - last stage may advance when !valid_last or CDB_valid.
  - stage s may advance when !valid_s or stage s+1 may advance.
  - in_ready = stage-0 may advance (combinational from CDB_valid).
- Capture:
  - stage 0 captures in_valid & in_ready.
  - a stage whose predecessor empties while it advances becomes invalid.
  - a stalled stage holds all fields.
- Latency and throughput: with no stall, an issue at edge t gives out_done high after edge t+NUM_STAGE-1, i.e. NUM_STAGE cycles issue-to-CDB. Throughput is 1 per cycle.
- CDB_valid while out_done=0 has no effect.
- Squash predicate: for an index i, d(i) = (i - ROB_rollback_idx) mod 2**ROB_W. An entry is younger, and squashed, iff 0 < d(i) < d(ROB_tail_idx). The branch itself (d=0) is never squashed.
- On ROB_rollback_en, at the same edge:
  - every stage valid whose ROB_idx is younger is cleared;
  - an incoming issue with a younger ROB_idx is not captured;
  - surviving entries advance normally.
  - Squashed bubbles count as empty for the same-cycle advance rule only from the next cycle; squash does not change that cycle's in_ready.
- Rollback coinciding with CDB_valid on a squashed final stage: the entry is dropped. The CDB arbiter squashes its own copy.
- Wrap-around: the predicate is purely modular; tail < rollback_idx is legal.
- Full: all NUM_STAGE valid and CDB_valid=0 → in_ready=0; no entry is lost or overwritten.

Test Plan:
1. Reset: assert reset for 2 cycles while in_valid=1 → out_done=0, out_result=0, out_ROB_idx=0; in_ready=1 after deassert.
2. MULQ 3×7, ROB 2, T 9, CDB_valid=1 → after NUM_STAGE=4 cycles: out_done=1, out_result=21, out_T_idx=9, out_ROB_idx=2 for exactly one cycle.
3. Back-to-back 8 MULQ issues (1×2, 64×2, 3×7, 5×66, 12×14, 57×89, 2×33, 24×75; ROB 1..8) → results 2, 128, 21, 330, 168, 5073, 66, 1800 on consecutive cycles, in order.
4. Modes:
   - UMULH 0xFFFF_FFFF_FFFF_FFFF × 2 → 1.
   - MULL 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
   - MULQ 0xFFFF_FFFF_FFFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
5. Stall: 6 issues with CDB_valid=0 → in_ready drops after the 4th accept, out_* held stable; raising CDB_valid drains the rest in order with no loss.
6. Rollback with ROB_W=3: stages hold ROB 3,4,5,6 and ROB 7 is issuing; pulse rollback_idx=5, tail_idx=2 → ROB 6 and 7 are dropped, ROB 3,4,5 still complete. Repeat with entries ROB 0,1 → both squashed (wrap), ROB 2 retained.
